uart_tx_param: RTL
==================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries, power of two, at least 2.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit, at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit, clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset, asynchronous, active-high.
REQ-006 The block SHALL have port wr_en, input, 1 bit, FIFO write request.
REQ-007 The block SHALL have port wr_data, input, DATA_W bits, word to enqueue.
REQ-008 The block SHALL have port parity_en, input, 1 bit, 1 = parity bit present.
REQ-009 The block SHALL have port parity_odd, input, 1 bit, 1 = odd parity, 0 = even parity.
REQ-010 The block SHALL have port two_stop, input, 1 bit, 1 = two stop bits, 0 = one stop bit.
REQ-011 The block SHALL have port tx, output, 1 bit, registered serial line, idle high.
REQ-012 The block SHALL have port tx_busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-013 The block SHALL have ports fifo_full and fifo_empty, outputs, 1 bit each, FIFO status.
REQ-014 The block SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits, occupied entries.
REQ-015 The block SHALL have port overflow, output, 1 bit, one-cycle pulse when a write is dropped.

Function
REQ-016 The FIFO SHALL accept a write when wr_en=1 and fifo_full=0, storing wr_data at the write pointer; both pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 When wr_en=1 and fifo_full=1, the write SHALL be dropped, and overflow SHALL pulse high for exactly the next cycle; FIFO contents and count SHALL be unchanged.
REQ-018 fifo_full is evaluated from the current state: with the FIFO full and a pop in the same cycle, a concurrent write SHALL still be dropped.
REQ-019 A simultaneous accepted write and pop SHALL leave fifo_count unchanged; otherwise fifo_count SHALL change by +1 or -1.
REQ-020 The FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-021 In IDLE with fifo_empty=0, on that edge the FSM SHALL pop the head word into the shift register, latch parity_en, parity_odd and two_stop, enter START, and drive tx low.
REQ-022 The parity bit SHALL be the XOR of the latched data bits, inverted when parity_odd=1; input changes mid-frame SHALL NOT affect the current frame.
REQ-023 Each bit SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads on every bit transition.
REQ-024 Bit order SHALL be: start (0), DATA_W data bits LSB first, parity (only if parity_en), then 1 or 2 stop bits (1).
REQ-025 Frame length SHALL be (1 + DATA_W + parity_en + 1 + two_stop) * CLKS_PER_BIT cycles.
REQ-026 At the end of the last stop bit, if fifo_empty=0, the FSM SHALL pop the next word and drive tx low on that same edge, with no idle gap; otherwise it SHALL return to IDLE with tx=1.
REQ-027 tx_busy SHALL be registered and high in START, DATA, PARITY and STOP.

Reset
REQ-028 Asserting rst SHALL immediately force tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, both pointers=0, baud and bit counters=0, and FSM=IDLE.
REQ-029 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents; after release the line SHALL stay high until a new write occurs.

Verification
REQ-030 Scenario: defaults, parity off, one stop bit, write 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles, 160 cycles total, then tx_busy=0.
REQ-031 Scenario: parity_en=1, parity_odd=0, write 0x07 -> parity bit 1; with parity_odd=1 -> parity bit 0; frame 176 cycles.
REQ-032 Scenario: FIFO_DEPTH=8, no tx drain, 9 writes -> fifo_full=1 after the 8th write, the 9th write raises overflow for one cycle, fifo_count=8.
REQ-033 Scenario: three back-to-back writes 0x01, 0x02, 0x03 -> three contiguous frames, no idle cycle between them, tx_busy continuously high for 480 cycles.
REQ-034 Scenario: two_stop=1 toggled to 0 in mid-frame -> the current frame still sends 2 stop bits, and the next frame sends 1.
REQ-035 Scenario: rst pulse during data bit 3 with 2 words queued -> tx=1 immediately, fifo_count=0, and no further frames without new writes.

Source files
------------

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - FIFO-buffered UART transmitter with run-time parity and stop-bit selection
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_en;
    logic              r_parity;
    logic              r_two_stop;
    logic              r_tx;
    logic              r_busy;

    state_t            w_state_nxt;
    logic              w_load;
    logic              w_tx_nxt;
    logic              w_busy_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_tick;
    logic [DATA_W-1:0] w_head;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;
    assign w_tick  = (r_baud == BAUD_LAST);
    assign w_head  = r_mem[r_rd_ptr];

    // Storage array carries no reset; occupancy is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_START;
                    w_load      = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_tick && r_bit == BIT_LAST) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // r_bit counts completed stop bits; a second one is owed only with two_stop latched.
                if (w_tick && !(r_two_stop && r_bit == '0)) begin
                    if (!w_empty) begin
                        w_state_nxt = S_START;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_nxt   = r_tx;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE:   w_tx_nxt = !w_load;
            S_START:  if (w_tick) w_tx_nxt = r_shift[0];
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == BIT_LAST) w_tx_nxt = r_par_en ? r_parity : 1'b1;
                    else                   w_tx_nxt = r_shift[1];
                end
            end
            S_PARITY: if (w_tick) w_tx_nxt = 1'b1;
            S_STOP:   if (w_tick) w_tx_nxt = !w_load;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_parity   <= 1'b0;
            r_two_stop <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_tx   <= w_tx_nxt;
            r_busy <= w_busy_nxt;
            if (r_state == S_IDLE || w_tick) r_baud <= '0;
            else                             r_baud <= r_baud + 1'b1;
            if (w_load) begin
                r_bit      <= '0;
                r_shift    <= w_head;
                r_parity   <= (^w_head) ^ parity_odd;
                r_par_en   <= parity_en;
                r_two_stop <= two_stop;
            end else if (w_tick) begin
                r_bit <= (w_state_nxt == r_state) ? r_bit + 1'b1 : '0;
                if (r_state == S_DATA) r_shift <= r_shift >> 1;
            end
        end
    end

    assign tx         = r_tx;
    assign tx_busy    = r_busy;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
